// File: rtl/fp16_pkg.sv
// Shared FP16 constants, series coefficients, ln2 multiples and FSM state for the log unit.
package fp16_pkg;

    localparam int unsigned FP16_W = 16;

    localparam logic [FP16_W-1:0] FP16_ONE     = 16'h3C00;
    localparam logic [FP16_W-1:0] FP16_NEG_ONE = 16'hBC00;
    localparam logic [FP16_W-1:0] FP16_NINF    = 16'hFC00;
    localparam logic [FP16_W-1:0] FP16_PINF    = 16'h7C00;
    localparam logic [FP16_W-1:0] FP16_QNAN    = 16'h7E00;

    // Fraction of sqrt(2): mantissas at or above this are halved so t stays small
    localparam logic [9:0] SQRT2_FRAC = 10'h1A8;

    // c_i = (-1)^(i+1)/i, i = 1..8
    localparam logic [8:1][FP16_W-1:0] LN_COEF = {
        16'hB000, 16'h3092, 16'hB155, 16'h3266,
        16'hB400, 16'h3555, 16'hB800, 16'h3C00
    };

    // Entry i holds (i-14)*ln2, i = 0..30
    localparam logic [30:0][FP16_W-1:0] LN2_ROM = {
        16'h498C, 16'h4933, 16'h48DA, 16'h4881, 16'h4829, 16'h47A0, 16'h46EE, 16'h463D,
        16'h458C, 16'h44DA, 16'h4429, 16'h42EE, 16'h418C, 16'h4029, 16'h3D8C, 16'h398C,
        16'h0000,
        16'hB98C, 16'hBD8C, 16'hC029, 16'hC18C, 16'hC2EE, 16'hC429, 16'hC4DA,
        16'hC58C, 16'hC63D, 16'hC6EE, 16'hC7A0, 16'hC829, 16'hC881, 16'hC8DA
    };

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_UNPACK,
        ST_HORNER,
        ST_SCALE,
        ST_COMBINE
    } ln_state_e;

endpackage

// File: rtl/fp16_add.sv
// Combinational FP16 adder, round-to-nearest-even, subnormals flushed to zero.
module fp16_add (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] y
);
    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [15:0]       big, sml;
    logic [4:0]        diff;
    logic [4:0]        shamt;
    logic [27:0]       ext;
    logic [14:0]       big_m, sml_m, sum;
    logic [13:0]       norm;
    logic [3:0]        lz;
    logic              found;
    logic signed [6:0] ex;
    logic [10:0]       rnd;

    always_comb begin
        a_nan  = (a[14:10] == 5'h1F) && (a[9:0] != 10'd0);
        b_nan  = (b[14:10] == 5'h1F) && (b[9:0] != 10'd0);
        a_inf  = (a[14:10] == 5'h1F) && (a[9:0] == 10'd0);
        b_inf  = (b[14:10] == 5'h1F) && (b[9:0] == 10'd0);
        a_zero = (a[14:10] == 5'd0);
        b_zero = (b[14:10] == 5'd0);
        big    = (a[14:0] >= b[14:0]) ? a : b;
        sml    = (a[14:0] >= b[14:0]) ? b : a;
        diff   = big[14:10] - sml[14:10];
        shamt  = (diff > 5'd15) ? 5'd15 : diff;
        ext    = {1'b1, sml[9:0], 3'b000, 14'd0} >> shamt;
        big_m  = {2'b01, big[9:0], 3'b000};
        // Bits shifted past the guard positions collapse into a sticky LSB
        sml_m  = {1'b0, ext[27:15], ext[14] | (|ext[13:0])};
        sum    = (a[15] ^ b[15]) ? (big_m - sml_m) : (big_m + sml_m);
        ex     = $signed({2'b00, big[14:10]});
        lz     = 4'd0;
        found  = 1'b0;
        for (int i = 13; i >= 0; i--) begin
            if (!found && sum[i]) begin
                lz    = 4'(13 - i);
                found = 1'b1;
            end
        end
        if (sum[14]) begin
            norm = {sum[14:2], sum[1] | sum[0]};
            ex   = ex + 7'sd1;
        end else begin
            norm = 14'(sum[13:0] << lz);
            ex   = ex - $signed({3'b000, lz});
        end
        rnd = {1'b0, norm[12:3]} + 11'(norm[2] & ((|norm[1:0]) | norm[3]));
        if (rnd[10]) begin
            ex = ex + 7'sd1;
        end
        y = {big[15], ex[4:0], rnd[9:0]};
        if (a_nan || b_nan) begin
            y = 16'h7E00;
        end else if (a_inf && b_inf) begin
            y = (a[15] != b[15]) ? 16'h7E00 : a;
        end else if (a_inf) begin
            y = a;
        end else if (b_inf) begin
            y = b;
        end else if (a_zero && b_zero) begin
            y = {a[15] & b[15], 15'd0};
        end else if (a_zero) begin
            y = b;
        end else if (b_zero) begin
            y = a;
        end else if (sum == 15'd0) begin
            y = 16'h0000;
        end else if (ex >= 7'sd31) begin
            y = {big[15], 5'h1F, 10'd0};
        end else if (ex <= 7'sd0) begin
            y = {big[15], 15'd0};
        end
    end

endmodule

// File: rtl/fp16_mult.sv
// Combinational FP16 multiplier, round-to-nearest-even, subnormals flushed to zero.
module fp16_mult (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] y
);
    logic              sign;
    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [21:0]       prod;
    logic signed [7:0] ex;
    logic [9:0]        mant;
    logic              guard, sticky;
    logic [10:0]       rnd;

    always_comb begin
        sign   = a[15] ^ b[15];
        a_nan  = (a[14:10] == 5'h1F) && (a[9:0] != 10'd0);
        b_nan  = (b[14:10] == 5'h1F) && (b[9:0] != 10'd0);
        a_inf  = (a[14:10] == 5'h1F) && (a[9:0] == 10'd0);
        b_inf  = (b[14:10] == 5'h1F) && (b[9:0] == 10'd0);
        a_zero = (a[14:10] == 5'd0);
        b_zero = (b[14:10] == 5'd0);
        prod   = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
        ex     = $signed({3'b000, a[14:10]}) + $signed({3'b000, b[14:10]}) - 8'sd15;
        mant   = prod[19:10];
        guard  = prod[9];
        sticky = |prod[8:0];
        // Product in [2,4): renormalise by one position
        if (prod[21]) begin
            mant   = prod[20:11];
            guard  = prod[10];
            sticky = |prod[9:0];
            ex     = ex + 8'sd1;
        end
        rnd = {1'b0, mant} + 11'(guard & (sticky | mant[0]));
        if (rnd[10]) begin
            ex = ex + 8'sd1;
        end
        y = {sign, ex[4:0], rnd[9:0]};
        if (a_nan || b_nan) begin
            y = 16'h7E00;
        end else if (a_inf || b_inf) begin
            y = (a_zero || b_zero) ? 16'h7E00 : {sign, 5'h1F, 10'd0};
        end else if (a_zero || b_zero) begin
            y = {sign, 15'd0};
        end else if (ex >= 8'sd31) begin
            y = {sign, 5'h1F, 10'd0};
        end else if (ex <= 8'sd0) begin
            y = {sign, 15'd0};
        end
    end

endmodule

// File: rtl/fp16_ln.sv
// Iterative FP16 natural log: ln(x) = e*ln2 + ln(m), ln(m) by Horner-evaluated series in t = m-1.
module fp16_ln
    import fp16_pkg::*;
#(
    parameter int unsigned N_TERMS = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] x,
    output logic [15:0] ln_x,
    output logic        done,
    output logic        busy
);
    localparam int unsigned CNT_W = 4;

    ln_state_e        state;
    logic [15:0]      x_r, t, p, lnm, special_val;
    logic [4:0]       e_idx;
    logic             special;
    logic [CNT_W-1:0] cnt;

    logic [4:0]       x_exp;
    logic [9:0]       x_frac;
    logic             hi_frac;
    logic             is_special;
    logic [15:0]      spec_sel;
    logic [15:0]      mul_a, mul_b, mul_y, add_a, add_b, add_y;

    assign x_exp   = x_r[14:10];
    assign x_frac  = x_r[9:0];
    assign hi_frac = (x_frac >= SQRT2_FRAC);

    // Operand classification; zero and subnormal both read as ln(0)
    always_comb begin
        is_special = 1'b1;
        spec_sel   = FP16_QNAN;
        if (x_exp == 5'h1F && x_frac != 10'd0) begin
            spec_sel = FP16_QNAN;
        end else if (x_exp == 5'd0) begin
            spec_sel = FP16_NINF;
        end else if (x_r[15]) begin
            spec_sel = FP16_QNAN;
        end else if (x_exp == 5'h1F) begin
            spec_sel = FP16_PINF;
        end else begin
            is_special = 1'b0;
        end
    end

    // Operand steering for the single shared multiplier and adder
    always_comb begin
        mul_a = 16'h0000;
        mul_b = 16'h0000;
        add_a = 16'h0000;
        add_b = 16'h0000;
        case (state)
            ST_UNPACK: begin
                add_a = {1'b0, hi_frac ? 5'd14 : 5'd15, x_frac};
                add_b = FP16_NEG_ONE;
            end
            ST_HORNER: begin
                mul_a = t;
                mul_b = p;
                add_a = LN_COEF[cnt];
                add_b = mul_y;
            end
            ST_SCALE: begin
                mul_a = t;
                mul_b = p;
            end
            ST_COMBINE: begin
                add_a = lnm;
                add_b = LN2_ROM[e_idx];
            end
            default: ;
        endcase
    end

    fp16_mult u_mult (
        .a (mul_a),
        .b (mul_b),
        .y (mul_y)
    );

    fp16_add u_add (
        .a (add_a),
        .b (add_b),
        .y (add_y)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            ln_x        <= 16'h0000;
            done        <= 1'b0;
            busy        <= 1'b0;
            x_r         <= 16'h0000;
            t           <= 16'h0000;
            p           <= 16'h0000;
            lnm         <= 16'h0000;
            special     <= 1'b0;
            special_val <= 16'h0000;
            e_idx       <= 5'd14;
            cnt         <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        x_r   <= x;
                        busy  <= 1'b1;
                        state <= ST_UNPACK;
                    end
                end
                ST_UNPACK: begin
                    t           <= add_y;
                    p           <= LN_COEF[N_TERMS];
                    cnt         <= CNT_W'(N_TERMS - 1);
                    special     <= is_special;
                    special_val <= spec_sel;
                    // ROM index is e+14, i.e. biased exponent minus one plus the halving bump
                    e_idx       <= (x_exp == 5'd0 || x_exp == 5'h1F) ? 5'd14
                                 : 5'(x_exp - 5'd1 + 5'(hi_frac));
                    state       <= ST_HORNER;
                end
                ST_HORNER: begin
                    p <= add_y;
                    if (cnt == CNT_W'(1)) begin
                        state <= ST_SCALE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_SCALE: begin
                    lnm   <= mul_y;
                    state <= ST_COMBINE;
                end
                ST_COMBINE: begin
                    ln_x  <= special ? special_val : add_y;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
